// File: rtl/aib_avmm_pkg.sv
// Shared definitions for the AIB AVMM CSR responder.
//   avmm_state_e    : responder FSM encoding (IDLE, WR_ACK, RD_WAIT, RD_DATA)
//   ID_VAL_DEFAULT  : default contents of the read-only identification word 0
//   RD_LAT_MAX      : largest supported read latency
//   LAT_CNT_W       : width of the read-latency down counter
package aib_avmm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_ACK  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_DATA = 2'd3
    } avmm_state_e;

    localparam logic [31:0] ID_VAL_DEFAULT = 32'hA1B2_0001;
    localparam int          RD_LAT_MAX     = 7;
    localparam int          LAT_CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/aib_avmm_regfile.sv
// Byte-enabled CSR word storage with a combinational read mux.
// Word 0 is a read-only identification constant; words 1..REG_NUM-1 are
// read/write flops cleared by reset.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : write strobe (already qualified with the window hit)
//   wr_idx    : word index to write
//   wr_be     : byte lanes to update
//   wr_data   : write data
//   rd_hit    : read address lies inside the window
//   rd_idx    : word index to read
//   rd_data   : selected word, zero when rd_hit is low
module aib_avmm_regfile #(
    parameter int                    AVMM_WIDTH = 32,
    parameter int                    BYTE_WIDTH = 4,
    parameter int                    REG_NUM    = 16,
    parameter int                    IDX_W      = 4,
    parameter logic [AVMM_WIDTH-1:0] ID_VAL     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [BYTE_WIDTH-1:0] wr_be,
    input  logic [AVMM_WIDTH-1:0] wr_data,
    input  logic                  rd_hit,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [AVMM_WIDTH-1:0] rd_data
);

    localparam int LANE_W = AVMM_WIDTH / BYTE_WIDTH;

    // Word 0 has no storage; only the writable words exist as flops.
    logic [AVMM_WIDTH-1:0] mem [1:REG_NUM-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < REG_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            // Index 0 never matches here, so writes to word 0 are dropped.
            for (int i = 1; i < REG_NUM; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    for (int b = 0; b < BYTE_WIDTH; b++) begin
                        if (wr_be[b]) begin
                            mem[i][b*LANE_W +: LANE_W] <= wr_data[b*LANE_W +: LANE_W];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            if (rd_idx == '0) begin
                rd_data = ID_VAL;
            end else begin
                for (int i = 1; i < REG_NUM; i++) begin
                    if (rd_idx == IDX_W'(i)) begin
                        rd_data = mem[i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/aib_avmm_csr_resp.sv
// AVMM slave responder for a small CSR window.
// Handshake: the master raises read or write and holds it (with address and
// data) until the cycle in which o_cfg_avmm_waitreq is low; that single low
// cycle is the acknowledge. A read acknowledge coincides with
// o_cfg_avmm_rdatavld. If the master withdraws its strobe before the
// acknowledge, the request is abandoned silently. At least one idle cycle
// must separate consecutive requests.
// Ports:
//   i_cfg_avmm_clk / i_cfg_avmm_rst : clock, synchronous active-high reset
//   i_cfg_avmm_addr                 : byte address (bits [1:0] ignored)
//   i_cfg_avmm_byte_en              : write byte lanes
//   i_cfg_avmm_read / _write        : request strobes
//   i_cfg_avmm_wdata                : write data
//   o_cfg_avmm_waitreq              : low for the one acknowledge cycle
//   o_cfg_avmm_rdatavld             : read data valid (one cycle)
//   o_cfg_avmm_rdata                : read data, zero when not valid
//   o_proto_err                     : sticky, read and write seen together
module aib_avmm_csr_resp
    import aib_avmm_pkg::*;
#(
    parameter int                    AVMM_WIDTH = 32,
    parameter int                    BYTE_WIDTH = 4,
    parameter int                    ADDR_WIDTH = 17,
    parameter int                    REG_NUM    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_LAT     = 2,
    parameter logic [AVMM_WIDTH-1:0] ID_VAL     = ID_VAL_DEFAULT
) (
    input  logic                  i_cfg_avmm_clk,
    input  logic                  i_cfg_avmm_rst,
    input  logic [ADDR_WIDTH-1:0] i_cfg_avmm_addr,
    input  logic [BYTE_WIDTH-1:0] i_cfg_avmm_byte_en,
    input  logic                  i_cfg_avmm_read,
    input  logic                  i_cfg_avmm_write,
    input  logic [AVMM_WIDTH-1:0] i_cfg_avmm_wdata,
    output logic                  o_cfg_avmm_waitreq,
    output logic                  o_cfg_avmm_rdatavld,
    output logic [AVMM_WIDTH-1:0] o_cfg_avmm_rdata,
    output logic                  o_proto_err
);

    localparam int                  IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH + 1)'(4 * REG_NUM);

    avmm_state_e           state;
    logic [LAT_CNT_W-1:0]  lat_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    logic [ADDR_WIDTH-1:0] wr_off;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic                  wr_hit;
    logic                  rd_hit;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  wr_fire;
    logic [AVMM_WIDTH-1:0] rd_word;

    // Window decode. The lower-bound test keeps addresses below BASE_ADDR
    // from wrapping into the window through the subtraction.
    assign wr_off = i_cfg_avmm_addr - BASE_ADDR;
    assign rd_off = rd_addr_q - BASE_ADDR;
    assign wr_hit = (i_cfg_avmm_addr >= BASE_ADDR) && ({1'b0, wr_off} < WIN_BYTES);
    assign rd_hit = (rd_addr_q >= BASE_ADDR) && ({1'b0, rd_off} < WIN_BYTES);
    assign wr_idx = wr_off[IDX_W+1:2];
    assign rd_idx = rd_off[IDX_W+1:2];

    // The write lands on the acknowledge edge, using address and data as
    // presented in the acknowledge cycle. A withdrawn strobe writes nothing.
    assign wr_fire = (state == ST_WR_ACK) && i_cfg_avmm_write && wr_hit;

    // The write acknowledge is gated by the live strobe so that a write
    // withdrawn after acceptance is never acknowledged.
    assign o_cfg_avmm_waitreq = !(((state == ST_WR_ACK) && i_cfg_avmm_write) ||
                                  (state == ST_RD_DATA));

    aib_avmm_regfile #(
        .AVMM_WIDTH (AVMM_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .REG_NUM    (REG_NUM),
        .IDX_W      (IDX_W),
        .ID_VAL     (ID_VAL)
    ) u_regfile (
        .clk     (i_cfg_avmm_clk),
        .rst     (i_cfg_avmm_rst),
        .wr_en   (wr_fire),
        .wr_idx  (wr_idx),
        .wr_be   (i_cfg_avmm_byte_en),
        .wr_data (i_cfg_avmm_wdata),
        .rd_hit  (rd_hit),
        .rd_idx  (rd_idx),
        .rd_data (rd_word)
    );

    always_ff @(posedge i_cfg_avmm_clk) begin
        if (i_cfg_avmm_rst) begin
            state               <= ST_IDLE;
            lat_cnt             <= '0;
            rd_addr_q           <= '0;
            o_cfg_avmm_rdatavld <= 1'b0;
            o_cfg_avmm_rdata    <= '0;
            o_proto_err         <= 1'b0;
        end else begin
            o_cfg_avmm_rdatavld <= 1'b0;
            o_cfg_avmm_rdata    <= '0;
            case (state)
                ST_IDLE: begin
                    if (i_cfg_avmm_write) begin
                        // Write wins a collision; the read is dropped.
                        state <= ST_WR_ACK;
                        if (i_cfg_avmm_read) begin
                            o_proto_err <= 1'b1;
                        end
                    end else if (i_cfg_avmm_read) begin
                        state     <= ST_RD_WAIT;
                        lat_cnt   <= LAT_CNT_W'(RD_LAT - 1);
                        rd_addr_q <= i_cfg_avmm_addr;
                    end
                end
                ST_WR_ACK: begin
                    state <= ST_IDLE;
                end
                ST_RD_WAIT: begin
                    if (!i_cfg_avmm_read) begin
                        state   <= ST_IDLE;
                        lat_cnt <= '0;
                    end else if (lat_cnt == '0) begin
                        // Data is registered here so it appears with the
                        // acknowledge in RD_DATA.
                        state               <= ST_RD_DATA;
                        o_cfg_avmm_rdatavld <= 1'b1;
                        o_cfg_avmm_rdata    <= rd_word;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aib_avmm_csr_resp.sv
module tb_aib_avmm_csr_resp;

    localparam int W = 32;
    localparam logic [W-1:0] ID = 32'hA1B2_0001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [16:0]   addr;
    logic [3:0]    be;
    logic [W-1:0]  wdata;
    logic          rd0, wr0, rd1, wr1;
    logic          wreq0, wreq1, vld0, vld1, perr0, perr1;
    logic [W-1:0]  rdata0, rdata1;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    int total = 0;
    int bad   = 0;

    aib_avmm_csr_resp #(.RD_LAT(2)) dut0 (
        .i_cfg_avmm_clk      (clk),
        .i_cfg_avmm_rst      (rst),
        .i_cfg_avmm_addr     (addr),
        .i_cfg_avmm_byte_en  (be),
        .i_cfg_avmm_read     (rd0),
        .i_cfg_avmm_write    (wr0),
        .i_cfg_avmm_wdata    (wdata),
        .o_cfg_avmm_waitreq  (wreq0),
        .o_cfg_avmm_rdatavld (vld0),
        .o_cfg_avmm_rdata    (rdata0),
        .o_proto_err         (perr0)
    );

    aib_avmm_csr_resp #(.RD_LAT(1)) dut1 (
        .i_cfg_avmm_clk      (clk),
        .i_cfg_avmm_rst      (rst),
        .i_cfg_avmm_addr     (addr),
        .i_cfg_avmm_byte_en  (be),
        .i_cfg_avmm_read     (rd1),
        .i_cfg_avmm_write    (wr1),
        .i_cfg_avmm_wdata    (wdata),
        .o_cfg_avmm_waitreq  (wreq1),
        .o_cfg_avmm_rdatavld (vld1),
        .o_cfg_avmm_rdata    (rdata1),
        .o_proto_err         (perr1)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_rd(input int d, input logic v);
        if (d == 0) rd0 = v; else rd1 = v;
    endtask

    task automatic set_wr(input int d, input logic v);
        if (d == 0) wr0 = v; else wr1 = v;
    endtask

    function automatic logic get_wreq(input int d);
        return (d == 0) ? wreq0 : wreq1;
    endfunction

    function automatic logic get_vld(input int d);
        return (d == 0) ? vld0 : vld1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    // ---------------- driver tasks ----------------
    // Write held until acknowledged; ack is expected on the second negedge
    // after the strobe goes up (one cycle in IDLE, then WR_ACK).
    task automatic do_write(input int d, input logic [16:0] a, input logic [W-1:0] dat,
                            input logic [3:0] b, input string name);
        int n;
        bit acked;
        @(posedge clk); #1;
        addr = a; wdata = dat; be = b; set_wr(d, 1'b1);
        n = 0; acked = 0;
        while (!acked && n < 10) begin
            @(negedge clk);
            n++;
            if (!get_wreq(d)) acked = 1;
        end
        check({name, "_ack_lat"}, W'(n), W'(2));
        @(posedge clk); #1;
        set_wr(d, 1'b0);
        @(posedge clk);
    endtask

    // Read held until data; lat counts clock edges from the first edge
    // that sees the strobe to the cycle in which rdatavld is high.
    task automatic do_read(input int d, input logic [16:0] a, input logic [W-1:0] exp,
                           input int lat_exp, input string name);
        int cyc;
        bit seen;
        if (d == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
        @(posedge clk); #1;
        addr = a; set_rd(d, 1'b1);
        cyc = 0; seen = 0;
        while (!seen && cyc < 12) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (get_vld(d)) seen = 1;
        end
        check({name, "_lat"}, W'(cyc), W'(lat_exp));
        if (!get_wreq(d)) check({name, "_wreq_with_data"}, 32'd0, 32'd0 + W'(0)) ; else check({name, "_wreq_with_data"}, W'(1), W'(0));
        @(posedge clk); #1;
        set_rd(d, 1'b0);
        @(posedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (vld0) begin
                if (exp_q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mon0_unexpected_vld: got rdatavld=1 data %h expected no valid", rdata0);
                end else begin
                    check("mon0_rdata", rdata0, exp_q0.pop_front());
                end
            end else begin
                check("mon0_rdata_idle_zero", rdata0, '0);
            end
            if (vld1) begin
                if (exp_q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mon1_unexpected_vld: got rdatavld=1 data %h expected no valid", rdata1);
                end else begin
                    check("mon1_rdata", rdata1, exp_q1.pop_front());
                end
            end else begin
                check("mon1_rdata_idle_zero", rdata1, '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; addr = '0; be = '0; wdata = '0;
        rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
        idle(3);
        @(negedge clk);
        check("rst_waitreq", W'(wreq0), W'(1));
        check("rst_rdatavld", W'(vld0), W'(0));
        check("rst_rdata", rdata0, '0);
        check("rst_proto_err", W'(perr0), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // ID word and latency
        do_read(0, 17'h0, ID, 3, "rd_id");

        // byte-lane write
        do_write(0, 17'h4, 32'h1234_5678, 4'b0101, "wr_be0101");
        do_read(0, 17'h4, 32'h0034_0078, 3, "rd_be0101");

        // word 0 is read-only but still acknowledged
        do_write(0, 17'h0, 32'hFFFF_FFFF, 4'b1111, "wr_ro");
        do_read(0, 17'h0, ID, 3, "rd_ro");

        // addr[1:0] ignored, partial lane merge
        do_write(0, 17'h8, 32'hA5A5_5A5A, 4'b1111, "wr_w2");
        do_write(0, 17'hA, 32'h1122_3344, 4'b1000, "wr_w2_hi");
        do_read(0, 17'h8, 32'h11A5_5A5A, 3, "rd_w2");

        // window boundaries
        do_write(0, 17'h3C, 32'hDEAD_BEEF, 4'b1111, "wr_last");
        do_read(0, 17'h3C, 32'hDEAD_BEEF, 3, "rd_last");
        do_write(0, 17'h40, 32'h5555_5555, 4'b1111, "wr_past_end");
        do_read(0, 17'h40, 32'h0, 3, "rd_past_end");
        do_write(0, 17'h44, 32'h7777_7777, 4'b1111, "wr_alias");
        do_read(0, 17'h4, 32'h0034_0078, 3, "rd_no_alias");
        do_read(0, 17'h100, 32'h0, 3, "rd_oow");

        // write withdrawn in WR_ACK: no ack, no update
        @(posedge clk); #1;
        addr = 17'h4; wdata = 32'hFFFF_FFFF; be = 4'b1111; wr0 = 1'b1;
        @(posedge clk); #1;
        wr0 = 1'b0;
        @(negedge clk);
        check("wr_drop_no_ack", W'(wreq0), W'(1));
        idle(2);
        do_read(0, 17'h4, 32'h0034_0078, 3, "rd_after_wr_drop");

        // read withdrawn in RD_WAIT: no ack, no data
        @(posedge clk); #1;
        addr = 17'h4; rd0 = 1'b1;
        @(posedge clk); #1;
        rd0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rd_drop_no_ack", W'(wreq0), W'(1));
        end

        // read + write collision: write wins, proto error sticky
        @(posedge clk); #1;
        addr = 17'h8; wdata = 32'hCAFE_F00D; be = 4'b1111; rd0 = 1'b1; wr0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rw_ack", W'(wreq0), W'(0));
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0;
        idle(5);
        @(negedge clk);
        check("rw_proto_err", W'(perr0), W'(1));
        do_read(0, 17'h8, 32'hCAFE_F00D, 3, "rd_rw_data");
        check("proto_err_sticky", W'(perr0), W'(1));

        // reset during RD_WAIT aborts the read
        @(posedge clk); #1;
        addr = 17'h8; rd0 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; rd0 = 1'b0;
        @(negedge clk);
        check("rst_abort_waitreq", W'(wreq0), W'(1));
        check("rst_abort_vld", W'(vld0), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        @(negedge clk);
        check("rst_clears_proto_err", W'(perr0), W'(0));
        do_read(0, 17'h8, 32'h0, 3, "rd_after_rst");
        do_read(0, 17'h0, ID, 3, "rd_id_after_rst");

        // RD_LAT=1 build
        do_write(1, 17'h4, 32'h1234_5678, 4'b0101, "l1_wr");
        do_read(1, 17'h4, 32'h0034_0078, 2, "l1_rd");

        idle(3);
        check("sb0_drained", W'(exp_q0.size()), W'(0));
        check("sb1_drained", W'(exp_q1.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit
    initial begin
        #500000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
